product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulation stage directly downstream of the 6x6 Wallace-tree multiplier. It consumes the 12-bit unsigned product stream through a valid/ready handshake and sums a fixed block of N_TERMS products into a wider accumulator. It presents each block sum on a registered valid/ready output with a sticky overflow flag. It turns the combinational multiplier into a multiply-accumulate datapath for dot-product style workloads.

## Interface
- PROD_W, 12: product width; matches the multiplier's P output.
- ACC_W, 20: accumulator and sum width; must be >= PROD_W.
- N_TERMS, 8: products per block; must be >= 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous abort of the current block.
- in_valid  input  1  in_product is valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  out_sum/out_ovf hold a completed block.
- out_ready  input  1  downstream accepts the sum.
- out_sum  output  ACC_W  block sum, modulo 2^ACC_W.
- out_ovf  output  1  at least one carry out of ACC_W occurred in this block.
- busy  output  1  a block is partially accumulated (state ACCUM).

## Operation
- States: IDLE, ACCUM, DONE. Term counter is clog2(N_TERMS+1) bits wide.
- An accept happens when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in DONE, and 0 while rst_n = 0.
- IDLE, on accept: acc <= zero-extended in_product (load, not add); ovf <= 0; cnt <= 1.
  - If N_TERMS == 1, go to DONE; otherwise go to ACCUM.
- ACCUM, on accept: {carry, acc} <= acc + in_product; ovf <= ovf | carry; cnt <= cnt + 1.
  - When cnt + 1 == N_TERMS, go to DONE.
- ACCUM with no accept: hold all state. Bubbles are allowed indefinitely.
- DONE: out_valid = 1; out_sum = acc; out_ovf = ovf. All of these hold stable until out_ready = 1.
  - On out_ready, go to IDLE and clear cnt. acc and out_sum keep their last value until the next load.
- Arithmetic: unsigned only; the sum wraps mod 2^ACC_W, and the wrap is reported via out_ovf.
- clear = 1, from any state: next state IDLE, cnt <= 0, ovf <= 0, out_valid <= 0. The product presented that cycle is not accepted (in_ready is forced 0 when clear = 1).
- Priority: rst_n low > clear > handshake logic.
- busy = 1 exactly when the state is ACCUM.

## Timing
- Reset values (rst_n sampled low at an edge): state IDLE, out_valid 0, out_sum 0, out_ovf 0, busy 0, cnt 0.
- Resetting mid-block discards the partial sum without producing output.
- All outputs are registered or decoded from state only; there is no combinational path from in_* or out_ready to any output.
  - Exception: in_ready depends on clear combinationally.
- Latency: out_valid rises in the cycle after the accept of term N_TERMS.
- Minimum block period is N_TERMS + 1 cycles: N_TERMS accept cycles plus one DONE cycle with out_ready held high.
- A product offered while in DONE stalls (in_ready = 0). It is accepted in the first cycle after the DONE handshake, which starts the next block.
- out_ready while out_valid = 0 is ignored.
- clear and out_ready both high in DONE: clear wins, with the same outcome (IDLE). out_valid drops the next cycle.
- in_valid may deassert at any point; the block neither drops nor duplicates terms.

## Test plan
- Reset then burst: 8 back-to-back products of 3969 (63*63) -> out_valid one cycle after the 8th accept, out_sum = 31752, out_ovf = 0, busy high for cycles 2-8.
- Bubbles: products 1, 2, 3, 4, 5, 6, 7, 8 with in_valid deasserted for 2 cycles between each -> out_sum = 36, with the same result as the gap-free run.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with value 100 -> in_ready = 0 and out_sum stable at its value. On release, 100 becomes term 1 of the next block.
- Overflow, with ACC_W = 14: 8 x 3969 -> out_sum = 31752 mod 16384 = 15368, out_ovf = 1. The next block of 8 x 1 gives out_sum = 8, out_ovf = 0.
- Clear mid-block: 3 terms of 500, then clear with in_valid = 1 and value 7 -> 7 is not accepted, busy = 0. The next 8 terms of 10 give out_sum = 80.
- Reset mid-block, then N_TERMS = 1 instance: rst_n low after 4 terms -> all outputs return to reset values. With N_TERMS = 1, product 4095 gives out_valid the next cycle with out_sum = 4095.

Source files
------------

// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Groups the product-stream handshake, the block-sum output handshake and
//   the clear/busy side signals of the product accumulator.
//   Modports:
//     master : the environment side. It drives in_valid, in_product,
//              out_ready and clear, and observes the rest.
//     slave  : the accumulator side.
//   Signals:
//     in_valid/in_ready/in_product : product stream (PROD_W bits, unsigned)
//     out_valid/out_ready/out_sum/out_ovf : block sum (ACC_W bits) + overflow
//     clear : synchronous abort of the current block
//     busy  : a block is partially accumulated
interface product_accumulator_if #(
  parameter int unsigned PROD_W = 12,
  parameter int unsigned ACC_W  = 20
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic              clear;
  logic              busy;

  modport master (
    output in_valid, in_product, out_ready, clear,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_product, out_ready, clear,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums fixed blocks of N_TERMS unsigned products (from the 6x6 multiplier)
//   into an ACC_W-bit accumulator. Each block sum is presented on a
//   registered valid/ready output together with a sticky carry-out flag.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : product_accumulator_if slave modport (product stream in,
//             block sum out, clear, busy)
module product_accumulator #(
  parameter int unsigned PROD_W  = 12,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned N_TERMS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  // Counter value held while the final term of a block is being accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic             accept;
  logic [ACC_W:0]   sum_ext;

  // in_ready is the only output with a combinational input dependency:
  // clear (and reset) must block the product offered in the same cycle.
  assign bus.in_ready = rst_n && !bus.clear && (state != DONE);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W + 1)'(bus.in_product);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // First term loads rather than adds, so acc never needs zeroing.
            acc <= ACC_W'(bus.in_product);
            ovf <= 1'b0;
            cnt <= CNT_W'(1);
            if (N_TERMS == 1) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= sum_ext[ACC_W-1:0];
            ovf <= ovf | sum_ext[ACC_W];
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign bus.busy      = (state == ACCUM);

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Self-checking bench for product_accumulator. Three instances share the
//   same stimulus: default (ACC_W=20, N_TERMS=8), narrow (ACC_W=14) and
//   single-term (N_TERMS=1); sel chooses which instance is observed.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] in_product;
  int unsigned sel;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(12), .ACC_W(20)) bus_a ();
  product_accumulator_if #(.PROD_W(12), .ACC_W(14)) bus_b ();
  product_accumulator_if #(.PROD_W(12), .ACC_W(20)) bus_c ();

  assign bus_a.in_valid = in_valid;  assign bus_a.in_product = in_product;
  assign bus_a.out_ready = out_ready; assign bus_a.clear = clear;
  assign bus_b.in_valid = in_valid;  assign bus_b.in_product = in_product;
  assign bus_b.out_ready = out_ready; assign bus_b.clear = clear;
  assign bus_c.in_valid = in_valid;  assign bus_c.in_product = in_product;
  assign bus_c.out_ready = out_ready; assign bus_c.clear = clear;

  product_accumulator #(.PROD_W(12), .ACC_W(20), .N_TERMS(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  product_accumulator #(.PROD_W(12), .ACC_W(14), .N_TERMS(8)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  product_accumulator #(.PROD_W(12), .ACC_W(20), .N_TERMS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));

  logic        cur_in_ready, cur_out_valid, cur_out_ovf, cur_busy;
  logic [19:0] cur_out_sum;

  always_comb begin
    cur_in_ready  = bus_a.in_ready;
    cur_out_valid = bus_a.out_valid;
    cur_out_sum   = bus_a.out_sum;
    cur_out_ovf   = bus_a.out_ovf;
    cur_busy      = bus_a.busy;
    if (sel == 1) begin
      cur_in_ready  = bus_b.in_ready;
      cur_out_valid = bus_b.out_valid;
      cur_out_sum   = 20'(bus_b.out_sum);
      cur_out_ovf   = bus_b.out_ovf;
      cur_busy      = bus_b.busy;
    end else if (sel == 2) begin
      cur_in_ready  = bus_c.in_ready;
      cur_out_valid = bus_c.out_valid;
      cur_out_sum   = bus_c.out_sum;
      cur_out_ovf   = bus_c.out_ovf;
      cur_busy      = bus_c.busy;
    end
  end

  typedef struct {
    logic [19:0] sum;
    logic        ovf;
  } exp_t;

  typedef struct {
    int unsigned base;
    int unsigned step;
    int unsigned gap;
    logic [19:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic push_exp(input logic [19:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [11:0] p);
    int k;
    k = 0;
    in_valid   = 1'b1;
    in_product = p;
    #1;
    while (!cur_in_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!cur_in_ready) timeout_fail("send");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int unsigned base, input int unsigned step,
                            input int unsigned gap, input logic [19:0] s,
                            input logic o, input bit do_push);
    for (int t = 0; t < 8; t++) begin
      if (t == 7 && do_push) push_exp(s, o);
      send(12'(base + step * t));
      if (t != 7) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) timeout_fail("drain");
    @(negedge clk);
  endtask

  // Holds reset across two edges and checks reset values while it is low.
  task automatic do_reset();
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", cur_out_valid, 0);
    check("rst_out_sum", cur_out_sum, 0);
    check("rst_out_ovf", cur_out_ovf, 0);
    check("rst_busy", cur_busy, 0);
    check("rst_in_ready", cur_in_ready, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Output monitor: a sum is consumed when out_valid && out_ready at the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !clear && cur_out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", cur_out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("out_sum", cur_out_sum, e.sum);
          check("out_ovf", cur_out_ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{base: 1,    step: 1,   gap: 2, exp_sum: 20'd36,    exp_ovf: 1'b0};
    vecs[1] = '{base: 1,    step: 1,   gap: 0, exp_sum: 20'd36,    exp_ovf: 1'b0};
    vecs[2] = '{base: 4095, step: 0,   gap: 1, exp_sum: 20'd32760, exp_ovf: 1'b0};
    vecs[3] = '{base: 1000, step: 100, gap: 0, exp_sum: 20'd10800, exp_ovf: 1'b0};
    vecs[4] = '{base: 0,    step: 0,   gap: 0, exp_sum: 20'd0,     exp_ovf: 1'b0};
    vecs[5] = '{base: 2048, step: 0,   gap: 3, exp_sum: 20'd16384, exp_ovf: 1'b0};

    sel        = 0;
    in_product = '0;
    do_reset();

    // Back-to-back burst: busy after accepts 1..7, out_valid right after the 8th.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(20'd31752, 1'b0);
      send(12'd3969);
      #1;
      if (i < 7) begin
        check("burst_busy", cur_busy, 1);
        check("burst_no_valid", cur_out_valid, 0);
      end else begin
        check("burst_valid", cur_out_valid, 1);
        check("burst_busy_done", cur_busy, 0);
      end
    end
    drain();

    for (int v = 0; v < 6; v++) begin
      send_block(vecs[v].base, vecs[v].step, vecs[v].gap,
                 vecs[v].exp_sum, vecs[v].exp_ovf, 1'b1);
      drain();
    end

    // Backpressure in DONE with a product waiting.
    out_ready = 1'b0;
    send_block(50, 0, 0, 20'd400, 1'b0, 1'b1);
    in_valid   = 1'b1;
    in_product = 12'd100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", cur_in_ready, 0);
      check("bp_out_valid", cur_out_valid, 1);
      check("bp_out_sum", cur_out_sum, 400);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send_block(100, 0, 0, 20'd800, 1'b0, 1'b1);
    drain();

    // clear together with out_ready in DONE: no sum is consumed.
    out_ready = 1'b0;
    send_block(2, 0, 0, 20'd16, 1'b0, 1'b0);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_done_valid", cur_out_valid, 0);
    check("clr_done_busy", cur_busy, 0);
    @(negedge clk);

    // clear mid-block: the product offered with clear is not taken.
    for (int i = 0; i < 3; i++) send(12'd500);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_product = 12'd7;
    #1;
    check("clr_in_ready", cur_in_ready, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_busy", cur_busy, 0);
    check("clr_out_valid", cur_out_valid, 0);
    @(negedge clk);
    send_block(10, 0, 0, 20'd80, 1'b0, 1'b1);
    drain();

    // Reset mid-block discards the partial sum.
    for (int i = 0; i < 4; i++) send(12'd1234);
    do_reset();
    send_block(5, 0, 0, 20'd40, 1'b0, 1'b1);
    drain();

    // Narrow accumulator: wrap and sticky overflow, then a clean block.
    sel = 1;
    do_reset();
    send_block(3969, 0, 0, 20'd15368, 1'b1, 1'b1);
    drain();
    send_block(1, 0, 0, 20'd8, 1'b0, 1'b1);
    drain();

    // Single-term blocks.
    sel = 2;
    do_reset();
    push_exp(20'd4095, 1'b0);
    send(12'd4095);
    #1;
    check("n1_valid", cur_out_valid, 1);
    check("n1_sum", cur_out_sum, 4095);
    check("n1_busy", cur_busy, 0);
    drain();
    push_exp(20'd10, 1'b0);
    send(12'd10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
